// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter for the dual-clock FIFO, write-clock domain.
// Grants one requester per burst; a burst ends on last or after MAXBURST beats, and wfull stalls the port.
module fifo_wr_arb #(
  parameter int DSIZE    = 80,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 8,
  localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW      = $clog2(MAXBURST + 1)
) (
  input  logic                   wclk,
  input  logic                   wrst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ*DSIZE-1:0]  req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   wfull,
  output logic [DSIZE-1:0]       wdata,
  output logic                   winc,
  output logic [GW-1:0]          grant_id,
  output logic                   busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_prev;
  logic [CW-1:0]   r_beat_cnt;

  logic [DSIZE-1:0] w_data_arr [NREQ];
  logic [GW-1:0]    w_next;
  logic [GW-1:0]    w_scan_idx;
  logic             w_found;
  logic             w_grant_active;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic             w_beat_end;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_data_arr[i] = req_data[i*DSIZE +: DSIZE];
  end

  // Round-robin scan: first valid requester at or after prev+1, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    w_found    = 1'b0;
    w_next     = '0;
    w_scan_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_scan_idx = GW'((int'(r_prev) + k) % NREQ);
      if (!w_found && req_valid[w_scan_idx]) begin
        w_found = 1'b1;
        w_next  = w_scan_idx;
      end
    end
  end

  assign w_grant_active = (r_state == ST_GRANT);
  assign w_sel_valid    = req_valid[r_grant];
  assign w_sel_last     = req_last[r_grant];

  assign winc      = w_grant_active & w_sel_valid & ~wfull;
  assign wdata     = w_data_arr[r_grant];
  assign busy      = w_grant_active;
  assign grant_id  = r_grant;
  assign w_beat_end = w_sel_last | (r_beat_cnt == CW'(MAXBURST - 1));

  always_comb begin
    req_ready = '0;
    if (w_grant_active && !wfull) req_ready[r_grant] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_prev     <= GW'(NREQ - 1);
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant    <= w_next;
            r_beat_cnt <= '0;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // The grant is held through valid gaps; only an accepted beat can end the burst.
          if (winc) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
            if (w_beat_end) begin
              r_prev  <= r_grant;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: per-requester beat queues feed the DUT and a monitor logs every FIFO write.
module tb_fifo_wr_arb;
  localparam int DSIZE    = 80;
  localparam int NREQ     = 4;
  localparam int MAXBURST = 8;
  localparam int GW       = $clog2(NREQ);

  typedef struct {
    logic [DSIZE-1:0] data;
    logic             last;
  } beat_t;

  typedef struct {
    int               cyc;
    logic [GW-1:0]    id;
    logic [DSIZE-1:0] data;
  } log_t;

  logic                  wclk   = 1'b0;
  logic                  wrst_n = 1'b1;
  logic                  wfull  = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_last  = '0;
  logic [NREQ*DSIZE-1:0] req_data  = '0;
  logic [NREQ-1:0]       req_ready;
  logic [DSIZE-1:0]      wdata;
  logic                  winc;
  logic [GW-1:0]         grant_id;
  logic                  busy;

  beat_t           src_q [NREQ][$];
  logic [NREQ-1:0] src_en = '1;
  log_t            log_q [$];
  int              cyc    = 0;
  int              checks = 0;
  int              errors = 0;

  fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .wdata     (wdata),
    .winc      (winc),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  // Source model: pops a beat when it was accepted at the edge, then presents the queue head.
  always begin : src_driver
    logic [NREQ-1:0] acc;
    @(posedge wclk);
    acc = req_valid & req_ready;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_en[i] && src_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_last[i]  = src_q[i][0].last;
        req_data[i*DSIZE +: DSIZE] = src_q[i][0].data;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  end

  // FIFO-side monitor: every write is logged with its edge number and grant.
  always @(posedge wclk) begin
    cyc++;
    if (winc === 1'b1) begin
      checks++;
      if (wfull !== 1'b0) begin
        errors++;
        $display("FAIL winc_while_full: wfull=%b at write, required 0", wfull);
      end
      log_q.push_back('{cyc, grant_id, wdata});
    end
  end

  task automatic push_beat(input int r, input logic [DSIZE-1:0] d, input logic l);
    src_q[r].push_back('{d, l});
  endtask

  task automatic flush_sources();
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
  endtask

  task automatic reset_dut();
    @(negedge wclk);
    wrst_n = 1'b0;
    wfull  = 1'b0;
    src_en = '1;
    flush_sources();
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;
    log_q.delete();
  endtask

  task automatic test_reset();
    @(negedge wclk);
    wrst_n = 1'b0;
    wfull  = 1'b0;
    flush_sources();
    push_beat(1, 80'h1111, 1'b1);
    repeat (3) @(negedge wclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL reset_winc: got %b want 0", winc); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    wrst_n = 1'b1;
    log_q.delete();
    @(negedge wclk);
    checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL latency_grant: busy=%b id=%0d want busy=1 id=1", busy, grant_id); end
    checks++; if (winc !== 1'b1 || req_ready !== 4'b0010) begin errors++; $display("FAIL latency_beat: winc=%b ready=%b want 1/0010", winc, req_ready); end
    @(negedge wclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL latency_end: busy=%b want 0", busy); end
    checks++; if (log_q.size() != 1 || log_q[0].data !== 80'h1111) begin errors++; $display("FAIL latency_log: size=%0d want 1 with data 1111", log_q.size()); end
  endtask

  task automatic test_single_burst();
    int c;
    logic [DSIZE-1:0] exp_d [3];
    exp_d[0] = 80'hA; exp_d[1] = 80'hB; exp_d[2] = 80'hC;
    reset_dut();
    @(negedge wclk);
    c = cyc;
    push_beat(2, 80'hA, 1'b0);
    push_beat(2, 80'hB, 1'b0);
    push_beat(2, 80'hC, 1'b1);
    repeat (2) @(negedge wclk);
    checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL single_grant: busy=%b id=%0d want 1/2", busy, grant_id); end
    checks++; if (winc !== 1'b1 || req_ready !== 4'b0100 || wdata !== 80'hA) begin errors++; $display("FAIL single_first: winc=%b ready=%b wdata=%h want 1/0100/a", winc, req_ready, wdata); end
    repeat (3) @(negedge wclk);
    checks++; if (busy !== 1'b0 || grant_id !== 2'd2) begin errors++; $display("FAIL single_end: busy=%b id=%0d want 0/2", busy, grant_id); end
    checks++; if (log_q.size() != 3) begin errors++; $display("FAIL single_count: got %0d beats want 3", log_q.size()); end
    else begin
      for (int n = 0; n < 3; n++) begin
        checks++;
        if (log_q[n].data !== exp_d[n] || log_q[n].id !== 2'd2 || log_q[n].cyc != c + 3 + n)
          begin errors++; $display("FAIL single_beat%0d: data=%h id=%0d cyc=%0d want %h/2/%0d", n, log_q[n].data, log_q[n].id, log_q[n].cyc, exp_d[n], c + 3 + n); end
      end
    end
  endtask

  task automatic test_fairness();
    reset_dut();
    @(negedge wclk);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++) push_beat(i, DSIZE'(16 * i + k), 1'b1);
    repeat (3) @(negedge wclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fair_bubble: busy=%b want 0", busy); end
    @(negedge wclk);
    checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL fair_second: busy=%b id=%0d want 1/1", busy, grant_id); end
    repeat (16) @(negedge wclk);
    checks++; if (log_q.size() != 8) begin errors++; $display("FAIL fair_count: got %0d beats want 8", log_q.size()); end
    else begin
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (log_q[n].id !== GW'(n % 4) || log_q[n].data !== DSIZE'(16 * (n % 4) + n / 4) ||
            (n > 0 && log_q[n].cyc - log_q[n-1].cyc != 2))
          begin errors++; $display("FAIL fair_beat%0d: id=%0d data=%h want %0d/%h spaced 2", n, log_q[n].id, log_q[n].data, n % 4, 16 * (n % 4) + n / 4); end
      end
    end
  endtask

  task automatic test_burst_cap();
    logic [GW-1:0] exp_id [14];
    logic [DSIZE-1:0] exp_d [14];
    reset_dut();
    @(negedge wclk);
    for (int k = 0; k < 12; k++) push_beat(1, DSIZE'(8'h10 + k), k == 11);
    push_beat(3, 80'h30, 1'b0);
    push_beat(3, 80'h31, 1'b1);
    for (int n = 0; n < 8; n++)  begin exp_id[n] = 2'd1; exp_d[n] = DSIZE'(8'h10 + n); end
    exp_id[8] = 2'd3; exp_d[8] = 80'h30;
    exp_id[9] = 2'd3; exp_d[9] = 80'h31;
    for (int n = 10; n < 14; n++) begin exp_id[n] = 2'd1; exp_d[n] = DSIZE'(8'h10 + n - 2); end
    repeat (10) @(negedge wclk);
    checks++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL cap_release: busy=%b ready=%b want 0/0000", busy, req_ready); end
    repeat (15) @(negedge wclk);
    checks++; if (log_q.size() != 14) begin errors++; $display("FAIL cap_count: got %0d beats want 14", log_q.size()); end
    else begin
      for (int n = 0; n < 14; n++) begin
        checks++;
        if (log_q[n].id !== exp_id[n] || log_q[n].data !== exp_d[n])
          begin errors++; $display("FAIL cap_beat%0d: id=%0d data=%h want %0d/%h", n, log_q[n].id, log_q[n].data, exp_id[n], exp_d[n]); end
      end
      checks++; if (log_q[8].cyc - log_q[7].cyc != 2) begin errors++; $display("FAIL cap_bubble: gap=%0d want 2", log_q[8].cyc - log_q[7].cyc); end
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    @(negedge wclk);
    for (int k = 0; k < 10; k++) push_beat(0, DSIZE'(8'h50 + k), k == 9);
    repeat (4) @(negedge wclk);
    wfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (winc !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1)
        begin errors++; $display("FAIL bp_stall%0d: winc=%b ready=%b busy=%b want 0/0000/1", k, winc, req_ready, busy); end
      @(negedge wclk);
    end
    wfull = 1'b0;
    repeat (12) @(negedge wclk);
    checks++; if (log_q.size() != 10) begin errors++; $display("FAIL bp_count: got %0d beats want 10", log_q.size()); end
    else begin
      for (int n = 0; n < 10; n++) begin
        checks++;
        if (log_q[n].id !== 2'd0 || log_q[n].data !== DSIZE'(8'h50 + n))
          begin errors++; $display("FAIL bp_beat%0d: id=%0d data=%h want 0/%h", n, log_q[n].id, log_q[n].data, 8'h50 + n); end
      end
      checks++; if (log_q[2].cyc - log_q[1].cyc != 6) begin errors++; $display("FAIL bp_stall_len: gap=%0d want 6", log_q[2].cyc - log_q[1].cyc); end
      checks++; if (log_q[8].cyc - log_q[7].cyc != 2) begin errors++; $display("FAIL bp_cap_after_stall: gap=%0d want 2", log_q[8].cyc - log_q[7].cyc); end
    end
  endtask

  task automatic test_valid_gap();
    reset_dut();
    @(negedge wclk);
    for (int k = 0; k < 4; k++) push_beat(2, DSIZE'(8'h20 + k), k == 3);
    repeat (3) @(negedge wclk);
    src_en[2] = 1'b0;
    push_beat(0, 80'h77, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge wclk);
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'd2 || req_ready !== 4'b0100 || winc !== 1'b0)
        begin errors++; $display("FAIL gap_hold%0d: busy=%b id=%0d ready=%b winc=%b want 1/2/0100/0", k, busy, grant_id, req_ready, winc); end
    end
    src_en[2] = 1'b1;
    repeat (8) @(negedge wclk);
    checks++; if (log_q.size() != 5) begin errors++; $display("FAIL gap_count: got %0d beats want 5", log_q.size()); end
    else begin
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (log_q[n].id !== 2'd2 || log_q[n].data !== DSIZE'(8'h20 + n))
          begin errors++; $display("FAIL gap_beat%0d: id=%0d data=%h want 2/%h", n, log_q[n].id, log_q[n].data, 8'h20 + n); end
      end
      checks++; if (log_q[4].id !== 2'd0 || log_q[4].data !== 80'h77) begin errors++; $display("FAIL gap_next: id=%0d data=%h want 0/77", log_q[4].id, log_q[4].data); end
      checks++; if (log_q[2].cyc - log_q[1].cyc != 4) begin errors++; $display("FAIL gap_len: gap=%0d want 4", log_q[2].cyc - log_q[1].cyc); end
    end
  endtask

  task automatic test_reset_mid_burst();
    reset_dut();
    @(negedge wclk);
    for (int k = 0; k < 5; k++) push_beat(1, DSIZE'(8'h40 + k), k == 4);
    repeat (4) @(negedge wclk);
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL rst_pre_beats: got %0d want 2", log_q.size()); end
    wrst_n = 1'b0;
    #1;
    checks++;
    if (winc !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0)
      begin errors++; $display("FAIL rst_async: winc=%b ready=%b busy=%b id=%0d want 0/0000/0/0", winc, req_ready, busy, grant_id); end
    flush_sources();
    repeat (2) @(negedge wclk);
    push_beat(0, 80'hE0, 1'b1);
    push_beat(1, 80'hE1, 1'b1);
    wrst_n = 1'b1;
    log_q.delete();
    repeat (8) @(negedge wclk);
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL rst_post_count: got %0d beats want 2", log_q.size()); end
    else begin
      checks++; if (log_q[0].id !== 2'd0 || log_q[0].data !== 80'hE0) begin errors++; $display("FAIL rst_first: id=%0d data=%h want 0/e0", log_q[0].id, log_q[0].data); end
      checks++; if (log_q[1].id !== 2'd1 || log_q[1].data !== 80'hE1) begin errors++; $display("FAIL rst_second: id=%0d data=%h want 1/e1", log_q[1].id, log_q[1].data); end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_fairness();
    test_burst_cap();
    test_backpressure();
    test_valid_gap();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter for the dual-clock FIFO (`fifo1`), in the write-clock domain. NREQ requesters share the FIFO's single write port (`wdata`/`winc`). The block grants one requester at a time for a burst, ends the burst on `last` or after MAXBURST beats, and applies the FIFO's `wfull` as backpressure. It drives `wdata`/`winc` directly and takes `wfull` from the FIFO.

## Interface
- DSIZE, 80, data word width; must match the FIFO DSIZE.
- NREQ, 4, number of requesters, 2..16.
- MAXBURST, 8, maximum beats per grant, ≥1.
- wclk  input  1  write-domain clock, rising edge.
- wrst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NREQ  per-requester beat valid.
- req_last  input  NREQ  per-requester last beat of burst, qualified by valid.
- req_data  input  NREQ*DSIZE  requester i occupies bits [i*DSIZE +: DSIZE].
- req_ready  output  NREQ  one-hot or zero; beat from i accepted when req_valid[i] & req_ready[i].
- wfull  input  1  FIFO full flag (registered in FIFO, conservative).
- wdata  output  DSIZE  FIFO write data.
- winc  output  1  FIFO write strobe.
- grant_id  output  clog2(NREQ)  currently or last granted requester.
- busy  output  1  high while in GRANT.

## Operation
- Two-state FSM.
  - IDLE: no grant.
    - If any req_valid is set, choose the first set index scanning upward, modulo NREQ, from prev+1.
    - Register the choice into grant_id, clear beat_cnt, and go to GRANT.
    - If no req_valid is set, stay in IDLE.
  - GRANT: requester g = grant_id owns the port.
- Outputs in GRANT. These are combinational from registered state plus inputs.
  - req_ready[g] = ~wfull.
  - All other req_ready bits are 0.
  - winc = req_valid[g] & ~wfull.
  - wdata = req_data[g].
- Outputs in IDLE:
  - winc = 0 and req_ready = 0.
  - wdata = req_data[grant_id], a don't-care value.
- Beat counter:
  - Width is clog2(MAXBURST+1).
  - It increments on each accepted beat (winc).
- Burst end: on an accepted beat where req_last[g] = 1 or beat_cnt == MAXBURST-1.
  - Set prev := g and return to IDLE.
- The grant is held while req_valid[g] is low mid-burst.
  - There is no timeout.
  - Other requesters wait.
- winc is never asserted while wfull = 1. The FIFO also masks this internally; the arbiter gates it anyway.
- A requester asserting valid while not granted sees ready = 0. It must hold data/valid/last stable until accepted.
- Reset values:
  - state = IDLE.
  - grant_id = 0.
  - prev = NREQ-1, so requester 0 wins first.
  - beat_cnt = 0.
  - busy = 0.
  - req_ready = 0.
  - winc = 0.
- Reset mid-burst: immediate return to reset values. No partial-burst bookkeeping; the beats already written stay in the FIFO.

## Timing
- Arbitration latency is 1 cycle. A request seen in IDLE at edge N gives busy = 1 and a grant after edge N. The first beat can be accepted in the cycle after edge N.
- Throughput is 1 beat per wclk in GRANT when wfull = 0.
- There is 1 idle bubble cycle between consecutive bursts, even for back-to-back requesters.
- wfull sampled high in a cycle blocks acceptance in that same cycle. No beat is lost or duplicated across wfull toggles.
- Worst-case wait for any continuously requesting source is (NREQ-1) bursts × (MAXBURST+1) cycles, excluding wfull stall time.

## Test plan
- Single burst: requester 2 sends 3 beats (0xA, 0xB, 0xC), last on beat 3, wfull = 0.
  - grant_id = 2; winc is high for 3 consecutive cycles starting 1 cycle after the request.
  - FIFO reads back A, B, C; busy drops after beat 3.
- Fairness: all 4 requesters hold 1-beat bursts continuously after reset.
  - Grant order is 0, 1, 2, 3, 0, 1…
  - Each grant lasts 1 cycle, with 1 IDLE cycle between grants.
- Burst cap: with MAXBURST = 8, requester 1 offers 12 beats without last, and requester 3 is also requesting.
  - Exactly 8 beats are accepted, then requester 3 is granted.
  - Requester 1's remaining 4 beats follow in its next grant.
- Backpressure: wfull is forced high for 5 cycles mid-burst.
  - winc = 0 and req_ready = 0 during those cycles.
  - Data order is preserved and the beat count is unchanged after release.
- Valid gap: the granted requester drops valid for 3 cycles mid-burst while requester 0 requests.
  - The grant is held, requester 0 receives no ready, and the burst completes on last.
- Reset mid-burst: wrst_n is asserted after 2 beats of a 5-beat burst.
  - winc, req_ready and busy go to 0 asynchronously.
  - After release, requester 0 is granted first.
